encoder4_2_rr: RTL and testbench
================================

# encoder4_2_rr

Registered 4-to-2 round-robin encoder: converts a 4-bit multi-hot request vector into a 2-bit index plus valid flag, rotating priority so that no requester starves. It is the encode-side counterpart of the 2-to-4 decoder. It is used wherever several sources in the pipeline compete for one shared resource (forwarding/writeback arbitration, debug/trace ports) and a single granted index must be presented downstream under a valid/ready handshake.

## Interface
- Parameters: none. Requester count (4) and index width (2) are fixed package constants.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  request vector; bit i set = requester i wants service; sampled on clk, no hold requirement
- ready  input  1  downstream accepts the current index this cycle
- out  output  2  granted requester index (registered)
- valid  output  1  out holds a live grant (registered)

## Operation
- State: ptr[1:0] (highest-priority requester), out_q[1:0], valid_q. Outputs drive directly from out_q and valid_q.
- Handshake: `hs = valid_q & ready`.
- Effective pointer: `eff = hs ? out_q + 1 (mod 4) : ptr`. The pointer advances only on an accepted grant.
- Load condition: `load = ~valid_q | ready`.
- On each rising clk edge with `load` asserted:
  - If req != 0: out_q <= first set bit scanning eff, eff+1, eff+2, eff+3 (mod 4); valid_q <= 1.
  - If req == 0: valid_q <= 0; out_q holds its old value.
- On each rising clk edge with `load` deasserted (valid_q=1, ready=0): out_q and valid_q hold. Changes on req are ignored until acceptance.
- ptr <= eff on every edge.
- All index arithmetic is 2-bit and wraps naturally: 3+1 = 0.
- Reset (async, any time, including mid-handshake): out=2'b00, valid=0, ptr=2'b00 immediately, without waiting for clk. The first edge after reset deassertion behaves as `load` with eff=0.

## Timing
- Latency: req sampled at edge k → out/valid valid after edge k, i.e. 1 cycle.
- Throughput: one grant per cycle while ready=1 and req != 0.
- Backpressure: while valid=1 and ready=0, out and valid are stable every cycle (AXI-style no-retract rule).
- Simultaneous acceptance and new request: the grant accepted at edge k and the next grant are both resolved at edge k, with no bubble. The next grant uses eff = accepted index + 1.
- Requests that arrive while valid_q=1 and ready=0 are not lost if still asserted when load next occurs. They are lost if deasserted before then; this is by design.
- Combinational path, req → scan → out_q D-input, is at most 8 gate levels of 50 ps each. It must fit within the CPU clock period.

## Structure
- Shared package holds:
  - N_REQ = 4
  - IDX_W = 2
  - RESET_IDX = 2'b00
- One natural sub-module: priority_enc4_2, a fixed-priority combinational encoder (bit 0 highest) with an `any` output.
- The top level:
  - rotates req right by eff;
  - feeds the rotated vector to priority_enc4_2;
  - adds eff (mod 4) to the result to recover the absolute index.
- Flops use the team's D flip-flop cell with async active-high reset: 5 flops total.

## Test plan
- Reset mid-operation: with valid=1 and out=2, assert reset between edges → out=0 and valid=0 within the same cycle. After release with req=4'b1000 and ready=1 → out=3, valid=1 after the first edge.
- Single requester: req=4'b0001 held, ready=1 → valid=1 after 1 edge, out=0 on every subsequent cycle; ptr has no effect.
- Full rotation: after reset, req=4'b1111 held, ready=1 → out sequence 0,1,2,3,0,1… with no gaps.
- Backpressure: req=4'b0110, ready=0 → out=1, valid=1, held for 5 cycles while req changes to 4'b0000. Then ready=1 with req=4'b0100 → next edge out=2, valid=1.
- Drain: valid=1, out=1, ready=1, req=4'b0000 → next edge valid=0, out stays 1. Then req=4'b0011 → out=0 (eff=2 wraps to 0).
- Wrap-around: after grant 2 is accepted (ptr=3), req=4'b1001 with ready=1 → out=3, then out=0, then out=3.

Source files
------------

// File: rtl/encoder4_2_rr_pkg.sv
// rtl/encoder4_2_rr_pkg.sv - shared constants for the round-robin 4-to-2 encoder
package encoder4_2_rr_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] RESET_IDX = 2'b00;

  // Rotate a request vector right by amt so that bit amt lands at position 0.
  function automatic logic [N_REQ-1:0] rotr_req(input logic [N_REQ-1:0] vec,
                                                input logic [IDX_W-1:0] amt);
    logic [N_REQ-1:0] r;
    logic [IDX_W-1:0] src;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      src  = IDX_W'(i) + amt;
      r[i] = vec[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder4_2_rr_priority_enc4_2.sv
// rtl/encoder4_2_rr_priority_enc4_2.sv - fixed-priority 4-to-2 encoder, bit 0 highest
import encoder4_2_rr_pkg::*;

module priority_enc4_2 (
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = RESET_IDX;
    any = |req;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
  end

endmodule

// File: rtl/encoder4_2_rr.sv
// rtl/encoder4_2_rr.sv - registered round-robin 4-to-2 encoder with valid/ready output
import encoder4_2_rr_pkg::*;

module encoder4_2_rr (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             ready,
  output logic [IDX_W-1:0] out,
  output logic             valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] out_q;
  logic             valid_q;

  logic             hs;
  logic             load;
  logic [IDX_W-1:0] eff;
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W-1:0] grant_idx;

  assign hs   = valid_q & ready;
  assign load = ~valid_q | ready;
  // An accepted grant hands priority to the requester just after it.
  assign eff  = hs ? out_q + 2'd1 : ptr;

  assign req_rot = rotr_req(req, eff);

  priority_enc4_2 u_penc (
    .req (req_rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign grant_idx = enc_idx + eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= RESET_IDX;
      out_q   <= RESET_IDX;
      valid_q <= 1'b0;
    end else begin
      ptr <= eff;
      if (load) begin
        valid_q <= enc_any;
        if (enc_any) out_q <= grant_idx;
      end
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_encoder4_2_rr.sv
// tb/tb_encoder4_2_rr.sv - self-checking bench for encoder4_2_rr
module tb_encoder4_2_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ready = 1'b0;
  logic [1:0] out;
  logic       valid;

  int vectors = 0;
  int miscompares = 0;

  int m_ptr = 0;
  int m_out = 0;
  int m_valid = 0;

  encoder4_2_rr dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ready (ready),
    .out   (out),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: grant the first requesting index at or after the priority
  // position, moving priority past each accepted grant.
  task automatic model_edge();
    int start;
    bit accepted;
    accepted = (m_valid == 1) && ready;
    start = accepted ? (m_out + 1) % 4 : m_ptr;
    if (m_valid == 0 || ready) begin
      if (req != 4'b0000) begin
        for (int k = 3; k >= 0; k--)
          if (req[(start + k) % 4]) m_out = (start + k) % 4;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    m_ptr = start;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".out"}, int'(out), m_out);
    check({tag, ".valid"}, int'(valid), m_valid);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_ptr = 0; m_out = 0; m_valid = 0;
    check("reset.out", int'(out), 0);
    check("reset.valid", int'(valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset mid-operation
    req = 4'b0100; ready = 1'b0;
    step("pre_rst");
    check("pre_rst.out2", int'(out), 2);
    reset = 1'b1;
    #2;
    m_ptr = 0; m_out = 0; m_valid = 0;
    check("async_rst.out", int'(out), 0);
    check("async_rst.valid", int'(valid), 0);
    #1;
    reset = 1'b0;
    req = 4'b1000; ready = 1'b1;
    step("post_rst");
    check("post_rst.out3", int'(out), 3);

    // Single requester
    do_reset();
    req = 4'b0001; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("single");
      check("single.out0", int'(out), 0);
    end

    // Full rotation
    do_reset();
    req = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("rot");
      check("rot.seq", int'(out), i % 4);
      check("rot.valid1", int'(valid), 1);
    end

    // Backpressure
    do_reset();
    req = 4'b0110; ready = 1'b0;
    step("bp_first");
    check("bp_first.out1", int'(out), 1);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step("bp_hold");
      check("bp_hold.out1", int'(out), 1);
      check("bp_hold.valid1", int'(valid), 1);
    end
    req = 4'b0100; ready = 1'b1;
    step("bp_release");
    check("bp_release.out2", int'(out), 2);

    // Drain
    do_reset();
    req = 4'b0010; ready = 1'b1;
    step("drain_fill");
    req = 4'b0000;
    step("drain");
    check("drain.valid0", int'(valid), 0);
    check("drain.out1", int'(out), 1);
    req = 4'b0011;
    step("drain_wrap");
    check("drain_wrap.out0", int'(out), 0);

    // Wrap-around
    do_reset();
    req = 4'b0100; ready = 1'b1;
    step("wrap_fill");
    req = 4'b1001;
    step("wrap1"); check("wrap1.out3", int'(out), 3);
    step("wrap2"); check("wrap2.out0", int'(out), 0);
    step("wrap3"); check("wrap3.out3", int'(out), 3);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
